// File: rtl/regfile_mp.sv
// Multi-port register file with a hardwired zero register, write priority,
// optional write-to-read forwarding and a per-register busy scoreboard.
module regfile_mp #(
    parameter int BITSIZE  = 64,
    parameter int REGSIZE  = 32,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1,
    localparam int ASEL    = $clog2(REGSIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_RD*ASEL-1:0]    ReadSelect,
    output logic [NUM_RD*BITSIZE-1:0] ReadData,
    output logic [NUM_RD-1:0]         ReadBusy,
    input  logic [NUM_WR*ASEL-1:0]    WriteSelect,
    input  logic [NUM_WR*BITSIZE-1:0] WriteData,
    input  logic [NUM_WR-1:0]         WriteEnable,
    input  logic                      IssueEnable,
    input  logic [ASEL-1:0]           IssueSelect,
    output logic                      Conflict
);

    localparam logic [ASEL:0]   REG_LIMIT = REGSIZE[ASEL:0];
    localparam bit              ZERO_EN   = (ZERO_REG < REGSIZE);
    localparam logic [ASEL-1:0] ZERO_SEL  = ZERO_REG[ASEL-1:0];
    localparam bit              BYPASS_EN = (BYPASS != 0);

    logic [BITSIZE-1:0] regs_r [REGSIZE];
    logic [REGSIZE-1:0] busy_r;
    logic               conflict_r;

    logic [ASEL-1:0]    wsel_s  [NUM_WR];
    logic [BITSIZE-1:0] wdata_s [NUM_WR];
    logic [NUM_WR-1:0]  wvalid_s;
    logic [NUM_WR-1:0]  win_s;
    logic               conflict_s;
    logic               issue_valid_s;

    // A select is usable when it names a real register other than the zero register.
    function automatic logic sel_ok(input logic [ASEL-1:0] sel);
        return ({1'b0, sel} < REG_LIMIT) && !(ZERO_EN && (sel == ZERO_SEL));
    endfunction

    // Write-port decode: a port wins unless a higher-index valid port hits the same register.
    always_comb begin : write_decode
        logic same_s;
        same_s     = 1'b0;
        conflict_s = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            wsel_s[j]   = WriteSelect[j*ASEL +: ASEL];
            wdata_s[j]  = WriteData[j*BITSIZE +: BITSIZE];
            wvalid_s[j] = rst && WriteEnable[j] && sel_ok(wsel_s[j]);
        end
        for (int j = 0; j < NUM_WR; j++) begin
            win_s[j] = wvalid_s[j];
            for (int k = j + 1; k < NUM_WR; k++) begin
                same_s     = wvalid_s[k] && (wsel_s[k] == wsel_s[j]);
                win_s[j]   = win_s[j] && !same_s;
                conflict_s = conflict_s || (wvalid_s[j] && same_s);
            end
        end
    end

    // Issue claims only apply outside reset and to usable registers.
    always_comb begin
        issue_valid_s = rst && IssueEnable && sel_ok(IssueSelect);
    end

    // Register array, scoreboard and collision flag; issue is applied last so a new producer keeps busy set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_r     <= '{default: '0};
            busy_r     <= '0;
            conflict_r <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (win_s[j]) begin
                    regs_r[wsel_s[j]] <= wdata_s[j];
                    busy_r[wsel_s[j]] <= 1'b0;
                end
            end
            if (issue_valid_s) begin
                busy_r[IssueSelect] <= 1'b1;
            end
            conflict_r <= conflict_s;
        end
    end

    // Combinational read ports with optional forwarding of the winning write.
    always_comb begin : read_ports
        logic [ASEL-1:0]    rsel_s;
        logic               match_s;
        logic               fwd_hit_s;
        logic [BITSIZE-1:0] fwd_data_s;
        logic               same_issue_s;
        ReadData     = '0;
        ReadBusy     = '0;
        rsel_s       = '0;
        match_s      = 1'b0;
        fwd_hit_s    = 1'b0;
        fwd_data_s   = '0;
        same_issue_s = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            rsel_s     = ReadSelect[i*ASEL +: ASEL];
            fwd_hit_s  = 1'b0;
            fwd_data_s = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                match_s    = win_s[j] && (wsel_s[j] == rsel_s);
                fwd_hit_s  = fwd_hit_s || match_s;
                fwd_data_s = fwd_data_s | ({BITSIZE{match_s}} & wdata_s[j]);
            end
            same_issue_s = issue_valid_s && (IssueSelect == rsel_s);
            if (!sel_ok(rsel_s)) begin
                ReadData[i*BITSIZE +: BITSIZE] = '0;
                ReadBusy[i]                    = 1'b0;
            end else if (BYPASS_EN && fwd_hit_s) begin
                ReadData[i*BITSIZE +: BITSIZE] = fwd_data_s;
                ReadBusy[i]                    = same_issue_s ? busy_r[rsel_s] : 1'b0;
            end else begin
                ReadData[i*BITSIZE +: BITSIZE] = regs_r[rsel_s];
                ReadBusy[i]                    = busy_r[rsel_s];
            end
        end
    end

    assign Conflict = conflict_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: drives a BYPASS=0 and a BYPASS=1 instance with the same
// stimulus and checks both against an architectural model of the register file.
module tb_regfile_mp;

    localparam int BW = 64;
    localparam int NR = 3;
    localparam int NW = 2;
    localparam int AS = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AS-1:0] rsel [NR];
    logic [AS-1:0] wsel [NW];
    logic [BW-1:0] wdat [NW];
    logic [NW-1:0] wen;
    logic          ien;
    logic [AS-1:0] isel;

    logic [NR*AS-1:0] read_select;
    logic [NW*AS-1:0] write_select;
    logic [NW*BW-1:0] write_data;
    logic [NR*BW-1:0] rd0, rd1;
    logic [NR-1:0]    rb0, rb1;
    logic             cf0, cf1;

    logic [BW-1:0] m_regs [32];
    bit            m_busy [32];
    bit            m_conf;
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) read_select[i*AS +: AS] = rsel[i];
        for (int j = 0; j < NW; j++) begin
            write_select[j*AS +: AS] = wsel[j];
            write_data[j*BW +: BW]   = wdat[j];
        end
    end

    regfile_mp #(.BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .ReadSelect(read_select), .ReadData(rd0), .ReadBusy(rb0),
        .WriteSelect(write_select), .WriteData(write_data), .WriteEnable(wen),
        .IssueEnable(ien), .IssueSelect(isel), .Conflict(cf0)
    );

    regfile_mp #(.BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .ReadSelect(read_select), .ReadData(rd1), .ReadBusy(rb1),
        .WriteSelect(write_select), .WriteData(write_data), .WriteEnable(wen),
        .IssueEnable(ien), .IssueSelect(isel), .Conflict(cf1)
    );

    // Expected read value: reg 31 is zero; with forwarding the highest enabled port targeting sel wins.
    function automatic logic [BW-1:0] exp_data(input logic [AS-1:0] sel, input bit byp);
        if (sel == 5'd31) return 64'd0;
        if (byp && rst) begin
            for (int j = NW - 1; j >= 0; j--) begin
                if (wen[j] && wsel[j] == sel) return wdat[j];
            end
        end
        return m_regs[sel];
    endfunction

    function automatic bit exp_busy(input logic [AS-1:0] sel, input bit byp);
        bit written;
        written = 1'b0;
        if (sel == 5'd31) return 1'b0;
        for (int j = 0; j < NW; j++) if (wen[j] && wsel[j] == sel) written = 1'b1;
        if (byp && rst && written && !(ien && isel == sel)) return 1'b0;
        return m_busy[sel];
    endfunction

    // Architectural state update at a rising edge.
    task automatic model_edge();
        if (!rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 64'd0;
                m_busy[r] = 1'b0;
            end
            m_conf = 1'b0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wen[j] && wsel[j] != 5'd31) begin
                    m_regs[wsel[j]] = wdat[j];
                    m_busy[wsel[j]] = 1'b0;
                end
            end
            if (ien && isel != 5'd31) m_busy[isel] = 1'b1;
            m_conf = (wen == 2'b11) && (wsel[0] == wsel[1]) && (wsel[0] != 5'd31);
        end
    endtask

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("%s.rd0[%0d]", tag, i), rd0[i*BW +: BW], exp_data(rsel[i], 1'b0));
            check($sformatf("%s.rd1[%0d]", tag, i), rd1[i*BW +: BW], exp_data(rsel[i], 1'b1));
            check($sformatf("%s.rb0[%0d]", tag, i), {63'd0, rb0[i]}, {63'd0, exp_busy(rsel[i], 1'b0)});
            check($sformatf("%s.rb1[%0d]", tag, i), {63'd0, rb1[i]}, {63'd0, exp_busy(rsel[i], 1'b1)});
        end
        check({tag, ".cf0"}, {63'd0, cf0}, {63'd0, m_conf});
        check({tag, ".cf1"}, {63'd0, cf1}, {63'd0, m_conf});
    endtask

    // Check combinational outputs mid-cycle, then advance one edge.
    task automatic cycle(input string tag);
        #2;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_reads(input logic [AS-1:0] a, input logic [AS-1:0] b, input logic [AS-1:0] c);
        rsel[0] = a;
        rsel[1] = b;
        rsel[2] = c;
    endtask

    function automatic logic [AS-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return 5'd4;
            1:       return 5'd7;
            2:       return 5'd9;
            3:       return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        rst = 1'b0;
        wen = 2'b00;
        ien = 1'b0;
        isel = 5'd0;
        for (int j = 0; j < NW; j++) begin
            wsel[j] = 5'd0;
            wdat[j] = 64'd0;
        end
        set_reads(5'd1, 5'd2, 5'd3);
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 64'd0;
            m_busy[r] = 1'b0;
        end
        m_conf = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        rst = 1'b1;

        // Reset state
        #2;
        check("reset.rd1", rd1, {NR*BW{1'b0}});
        check("reset.busy", {61'd0, rb1}, 64'd0);
        cycle("reset");

        // Basic write: forwarded immediately only with BYPASS=1
        wen = 2'b01; wsel[0] = 5'd4; wdat[0] = 64'hF;
        set_reads(5'd4, 5'd0, 5'd1);
        #2;
        check("wr4.same.byp0", rd0[BW-1:0], 64'd0);
        check("wr4.same.byp1", rd1[BW-1:0], 64'hF);
        cycle("wr4");
        wen = 2'b00;
        check("wr4.after.byp0", rd0[BW-1:0], 64'hF);
        cycle("wr4post");

        // Collision on reg 7: port 1 wins, Conflict pulses once
        wen = 2'b11; wsel[0] = 5'd7; wsel[1] = 5'd7; wdat[0] = 64'hA5; wdat[1] = 64'h5A;
        set_reads(5'd7, 5'd4, 5'd31);
        cycle("coll7");
        wen = 2'b00;
        check("coll7.data", rd0[BW-1:0], 64'h5A);
        check("coll7.conf", {63'd0, cf0}, 64'd1);
        cycle("coll7a");
        check("coll7.conf_drop", {63'd0, cf1}, 64'd0);
        cycle("coll7b");

        // Collision on the zero register never flags
        wen = 2'b11; wsel[0] = 5'd31; wsel[1] = 5'd31; wdat[0] = 64'hDEAD; wdat[1] = 64'hBEEF;
        ien = 1'b1; isel = 5'd31;
        cycle("coll31");
        wen = 2'b00; ien = 1'b0;
        check("coll31.conf", {63'd0, cf1}, 64'd0);
        check("coll31.read", rd1[2*BW +: BW], 64'd0);
        cycle("coll31a");

        // Scoreboard on reg 9
        set_reads(5'd9, 5'd7, 5'd4);
        ien = 1'b1; isel = 5'd9;
        cycle("iss9");
        ien = 1'b0;
        check("iss9.busy", {63'd0, rb0[0]}, 64'd1);
        wen = 2'b01; wsel[0] = 5'd9; wdat[0] = 64'h1234_5678_9ABC_DEF0;
        #2;
        check("wr9.same.busy1", {63'd0, rb1[0]}, 64'd0);
        cycle("wr9");
        wen = 2'b00;
        check("wr9.after.busy0", {63'd0, rb0[0]}, 64'd0);
        cycle("wr9post");
        wen = 2'b10; wsel[1] = 5'd9; wdat[1] = 64'h77; ien = 1'b1; isel = 5'd9;
        cycle("isswr9");
        wen = 2'b00; ien = 1'b0;
        check("isswr9.busy", {63'd0, rb1[0]}, 64'd1);
        cycle("isswr9post");

        // Reset mid-operation discards the concurrent write
        rst = 1'b0; wen = 2'b01; wsel[0] = 5'd4; wdat[0] = 64'h9999;
        cycle("midrst");
        rst = 1'b1; wen = 2'b00;
        set_reads(5'd4, 5'd9, 5'd7);
        check("midrst.r4", rd1[BW-1:0], 64'd0);
        check("midrst.busy", {61'd0, rb0}, 64'd0);
        cycle("midrst_post");

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) != 0);
            set_reads(pick(), pick(), pick());
            for (int j = 0; j < NW; j++) begin
                wsel[j] = pick();
                wdat[j] = {$urandom, $urandom};
            end
            wen  = 2'($urandom_range(0, 3));
            ien  = ($urandom_range(0, 2) == 0);
            isel = pick();
            cycle($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
